// File: rtl/wb_stage_if.sv
// wb_stage_if: bundles the writeback stage's upstream handshake, operand
// inputs and register-file/forwarding outputs.
//   master : upstream / test driver side (drives in_*, stall, flush)
//   slave  : the writeback stage itself (drives in_ready, wb_*)
// Parameter XLEN must match the wb_stage instance it is connected to.
interface wb_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic            stall;
    logic            flush;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_alu_out;
    logic [XLEN-1:0] in_data_out;
    logic [XLEN-1:0] in_csr;
    logic [1:0]      in_wb_sel;
    logic [2:0]      in_ld_funct3;
    logic [4:0]      in_rd;
    logic            in_reg_we;
    logic            wb_valid;
    logic            wb_we;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;

    modport master (
        output in_valid, stall, flush, in_pc, in_alu_out, in_data_out, in_csr,
               in_wb_sel, in_ld_funct3, in_rd, in_reg_we,
        input  in_ready, wb_valid, wb_we, wb_rd, wb_data
    );

    modport slave (
        input  in_valid, stall, flush, in_pc, in_alu_out, in_data_out, in_csr,
               in_wb_sel, in_ld_funct3, in_rd, in_reg_we,
        output in_ready, wb_valid, wb_we, wb_rd, wb_data
    );
endinterface

// File: rtl/wb_stage.sv
// wb_stage: registered writeback stage. Picks the writeback source
// (PC+PC_INC, ALU, extracted load data, CSR), extracts/extends loads, and
// holds the result in the MEM/WB register under valid/stall/flush control.
//   clock  : rising-edge clock
//   reset  : asynchronous active-low reset
//   bus    : wb_stage_if.slave (upstream inputs, in_ready, wb_* outputs)
//   instret: 64-bit retired-instruction counter, present only when the
//            WB_INSTRET_EN macro is defined
// Parameters: XLEN (32 or 64), PC_INC (link-address increment).
module wb_stage #(
    parameter int XLEN   = 32,
    parameter int PC_INC = 4
) (
    input  logic        clock,
    input  logic        reset,
    wb_stage_if.slave   bus
`ifdef WB_INSTRET_EN
    ,
    output logic [63:0] instret
`endif
);
    localparam int OFFW = $clog2(XLEN / 8);

    logic [OFFW-1:0] w_off;
    logic [OFFW-1:0] w_off_h;
    logic [OFFW-1:0] w_off_w;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [31:0]     w_word;
    logic [XLEN-1:0] w_load;
    logic [XLEN-1:0] w_src;

    logic            r_valid;
    logic            r_we;
    logic [4:0]      r_rd;
    logic [XLEN-1:0] r_data;

    // Misaligned accesses are not trapped: the low offset bits below the
    // access size are simply dropped.
    assign w_off   = bus.in_alu_out[OFFW-1:0];
    assign w_off_h = w_off & ~OFFW'(1);
    assign w_off_w = w_off & ~OFFW'(3);

    assign w_byte = 8'(bus.in_data_out >> {w_off, 3'b000});
    assign w_half = 16'(bus.in_data_out >> {w_off_h, 3'b000});
    assign w_word = 32'(bus.in_data_out >> {w_off_w, 3'b000});

    always_comb begin
        // Unknown funct3 (and LD on XLEN=64) pass the raw word through.
        w_load = bus.in_data_out;
        case (bus.in_ld_funct3)
            3'b000: w_load = XLEN'($signed(w_byte));
            3'b100: w_load = XLEN'(w_byte);
            3'b001: w_load = XLEN'($signed(w_half));
            3'b101: w_load = XLEN'(w_half);
            // On XLEN=32 the sign-extending cast is a plain copy.
            3'b010: w_load = XLEN'($signed(w_word));
            3'b110: if (XLEN == 64) w_load = XLEN'(w_word);
            default: ;
        endcase
    end

    always_comb begin
        w_src = bus.in_csr;
        case (bus.in_wb_sel)
            2'd0: w_src = bus.in_pc + XLEN'(PC_INC);
            2'd1: w_src = bus.in_alu_out;
            2'd2: w_src = w_load;
            default: w_src = bus.in_csr;
        endcase
    end

    // Flush beats stall; rd/data keep their old values whenever nothing
    // new is captured.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_we    <= 1'b0;
            r_rd    <= 5'd0;
            r_data  <= '0;
        end else if (bus.flush) begin
            r_valid <= 1'b0;
        end else if (!bus.stall) begin
            r_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_we   <= bus.in_reg_we;
                r_rd   <= bus.in_rd;
                r_data <= w_src;
            end
        end
    end

    assign bus.in_ready = ~bus.stall;
    assign bus.wb_valid = r_valid;
    assign bus.wb_we    = r_valid & r_we & (r_rd != 5'd0);
    assign bus.wb_rd    = r_rd;
    assign bus.wb_data  = r_data;

`ifdef WB_INSTRET_EN
    logic [63:0] r_instret;

    // The occupant retires when it leaves the register without being held.
    // Under flush+stall the held occupant is killed, so it is not counted.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_instret <= 64'd0;
        else if (r_valid && !bus.stall)
            r_instret <= r_instret + 64'd1;
    end

    assign instret = r_instret;
`endif
endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;
    localparam int XLEN   = 32;
    localparam int PC_INC = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    wb_stage_if #(.XLEN(XLEN)) bus ();

`ifdef WB_INSTRET_EN
    logic [63:0] instret;
    wb_stage #(.XLEN(XLEN), .PC_INC(PC_INC)) dut (
        .clock(clock), .reset(reset), .bus(bus), .instret(instret));
`else
    wb_stage #(.XLEN(XLEN), .PC_INC(PC_INC)) dut (
        .clock(clock), .reset(reset), .bus(bus));
`endif

    int n_cmp = 0;
    int n_bad = 0;
    bit run_chk = 1'b0;

    // Behavioural model state
    bit          e_valid = 1'b0;
    bit          e_we    = 1'b0;
    logic [4:0]  e_rd    = '0;
    logic [31:0] e_data  = '0;
    longint unsigned e_instret = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: computed with plain arithmetic on the access rules.
    function automatic logic [31:0] ref_wb(input logic [1:0] sel, input logic [31:0] pc,
                                           input logic [31:0] alu, input logic [31:0] dout,
                                           input logic [31:0] csr, input logic [2:0] f3);
        longint unsigned off, ho, b, h;
        off = alu % 4;
        ho  = off - (off % 2);
        b   = (dout >> (8 * off)) % 256;
        h   = (dout >> (8 * ho)) % 65536;
        case (sel)
            2'd0: return 32'((longint'(pc) + PC_INC) % (64'd1 << 32));
            2'd1: return alu;
            2'd3: return csr;
            default: case (f3)
                3'd0: return (b >= 128) ? 32'(b + 64'hFFFF_FF00) : 32'(b);
                3'd4: return 32'(b);
                3'd1: return (h >= 32768) ? 32'(h + 64'hFFFF_0000) : 32'(h);
                3'd5: return 32'(h);
                default: return dout;
            endcase
        endcase
    endfunction

    task automatic model_edge();
        if (!reset) begin
            e_valid = 0; e_we = 0; e_rd = 0; e_data = 0; e_instret = 0;
        end else begin
            if (e_valid && !bus.stall) e_instret++;
            if (bus.flush) e_valid = 0;
            else if (!bus.stall) begin
                e_valid = bus.in_valid;
                if (bus.in_valid) begin
                    e_we   = bus.in_reg_we;
                    e_rd   = bus.in_rd;
                    e_data = ref_wb(bus.in_wb_sel, bus.in_pc, bus.in_alu_out,
                                    bus.in_data_out, bus.in_csr, bus.in_ld_funct3);
                end
            end
        end
    endtask

    always @(negedge clock) begin
        if (run_chk) begin
            chk("in_ready", bus.in_ready, !bus.stall);
            chk("wb_valid", bus.wb_valid, e_valid);
            chk("wb_we",    bus.wb_we, e_valid && e_we && (e_rd != 0));
            chk("wb_rd",    bus.wb_rd, e_rd);
            chk("wb_data",  bus.wb_data, e_data);
`ifdef WB_INSTRET_EN
            chk("instret",  instret, e_instret);
`endif
        end
    end

    task automatic step();
        @(posedge clock);
        model_edge();
        @(negedge clock);
        #1;
    endtask

    task automatic put(input bit v, input logic [1:0] sel, input logic [2:0] f3,
                       input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] dout,
                       input logic [31:0] csr, input logic [4:0] rd, input bit we);
        bus.in_valid = v; bus.in_wb_sel = sel; bus.in_ld_funct3 = f3;
        bus.in_pc = pc; bus.in_alu_out = alu; bus.in_data_out = dout;
        bus.in_csr = csr; bus.in_rd = rd; bus.in_reg_we = we;
        bus.stall = 1'b0; bus.flush = 1'b0;
    endtask

    task automatic put_rand();
        put($urandom_range(3, 0) != 0, 2'($urandom), 3'($urandom), $urandom, $urandom,
            $urandom, $urandom, ($urandom_range(7, 0) == 0) ? 5'd0 : 5'($urandom), 1'($urandom));
    endtask

    initial begin
        put(1, 2'd1, 3'd0, 32'h0, 32'h1234, 32'h0, 32'h0, 5'd5, 1);
        run_chk = 1'b1;

        // Reset held with valid input: stage stays empty
        repeat (3) step();
        chk("rst valid", bus.wb_valid, 1'b0);
        chk("rst we",    bus.wb_we, 1'b0);
        chk("rst data",  bus.wb_data, 32'h0);

        // First edge after release captures
        reset = 1'b1;
        step();
        chk("post-rst valid", bus.wb_valid, 1'b1);
        chk("post-rst data",  bus.wb_data, 32'h1234);

        put(1, 2'd0, 3'd0, 32'h1000, 32'h0, 32'h0, 32'h0, 5'd1, 1); step();
        chk("pc+4", bus.wb_data, 32'h1004);
        put(1, 2'd0, 3'd0, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0, 5'd1, 1); step();
        chk("pc wrap", bus.wb_data, 32'h0);

        put(1, 2'd2, 3'b000, 0, 32'h3, 32'h80FF7F01, 0, 5'd2, 1); step();
        chk("LB off3", bus.wb_data, 32'hFFFF_FF80);
        put(1, 2'd2, 3'b100, 0, 32'h1, 32'h80FF7F01, 0, 5'd2, 1); step();
        chk("LBU off1", bus.wb_data, 32'h0000_007F);
        put(1, 2'd2, 3'b001, 0, 32'h2, 32'h80FF7F01, 0, 5'd2, 1); step();
        chk("LH off2", bus.wb_data, 32'hFFFF_80FF);
        put(1, 2'd2, 3'b101, 0, 32'h3, 32'h80FF7F01, 0, 5'd2, 1); step();
        chk("LHU off3", bus.wb_data, 32'h0000_80FF);
        put(1, 2'd2, 3'b111, 0, 32'h3, 32'h80FF7F01, 0, 5'd2, 1); step();
        chk("f3=111 raw", bus.wb_data, 32'h80FF_7F01);

        put(1, 2'd1, 3'd0, 0, 32'h55, 0, 0, 5'd0, 1); step();
        chk("x0 valid", bus.wb_valid, 1'b1);
        chk("x0 we",    bus.wb_we, 1'b0);

        // Stall with changing inputs: outputs frozen
        put(1, 2'd3, 3'd0, 0, 0, 0, 32'hCAFE_F00D, 5'd9, 1); step();
        for (int i = 0; i < 3; i++) begin
            put_rand(); bus.in_valid = 1'b1; bus.stall = 1'b1;
            step();
            chk("stall data",  bus.wb_data, 32'hCAFE_F00D);
            chk("stall ready", bus.in_ready, 1'b0);
        end

        // Flush beats stall
        put(1, 2'd1, 3'd0, 0, 32'h77, 0, 0, 5'd3, 1); step();
        bus.stall = 1'b1; bus.flush = 1'b1; step();
        chk("flush+stall valid", bus.wb_valid, 1'b0);

`ifdef WB_INSTRET_EN
        begin
            logic [63:0] base;
            put(0, 2'd1, 3'd0, 0, 0, 0, 0, 5'd0, 0); step();
            base = instret;
            for (int i = 0; i < 10; i++) begin
                if (i == 4) begin
                    for (int s = 0; s < 3; s++) begin
                        put(1, 2'd1, 3'd0, 0, i, 0, 0, 5'd4, 0); bus.stall = 1'b1; step();
                    end
                end
                put(1, 2'd1, 3'd0, 0, i, 0, 0, 5'd4, 0);
                if (i == 2 || i == 6) bus.flush = 1'b1;
                step();
            end
            put(0, 2'd1, 3'd0, 0, 0, 0, 0, 5'd0, 0); step(); step();
            chk("instret delta", instret - base, 64'd8);
        end
`endif

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            put_rand();
            bus.stall = ($urandom_range(4, 0) == 0);
            bus.flush = ($urandom_range(7, 0) == 0);
            step();
        end

        run_chk = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
Registered, parametrised writeback stage for the rv151 pipeline. Selects the writeback source from {PC+PC_INC, ALU result, load data, CSR read data} and performs byte/halfword/word load extraction with sign or zero extension. Holds the result in a MEM/WB pipeline register with valid/stall/flush control. Drives the register-file write port and the forwarding path.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64
PC_INC, 4, increment added to PC for the link-address source

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
in_valid  input  1  upstream instruction valid
in_ready  output  1  stage can accept; equals !stall
stall  input  1  hazard-unit hold; freezes the pipeline register
flush  input  1  kill; invalidates the register contents next edge
in_pc  input  XLEN  instruction PC
in_alu_out  input  XLEN  ALU result; also the load address, low bits give byte offset
in_data_out  input  XLEN  raw aligned data-memory word
in_csr  input  XLEN  CSR read data
in_wb_sel  input  2  source select: 0 = PC+PC_INC, 1 = ALU, 2 = load, 3 = CSR
in_ld_funct3  input  3  load type (RISC-V funct3)
in_rd  input  5  destination register index
in_reg_we  input  1  instruction writes rd
wb_valid  output  1  register holds a live instruction
wb_we  output  1  register-file write enable
wb_rd  output  5  register-file write index
wb_data  output  XLEN  register-file write data and forwarding value

Behaviour:
- Reset (reset=0, asynchronous): wb_valid, wb_rd and wb_data clear to 0. wb_we therefore reads 0. The stage comes out of reset empty.
- Latency: exactly one cycle from capture to outputs. The source mux and load extraction are combinational before the register.
- in_ready = !stall. This is combinational and does not depend on reset.
- Priority per clock edge, highest first:
  - flush=1: wb_valid <= 0. wb_rd and wb_data are don't-care but must hold their values.
  - stall=1: all registers hold.
  - in_valid=1: capture wb_valid <= 1, wb_rd, and the selected data.
  - Otherwise: wb_valid <= 0.
- wb_we = wb_valid & registered reg_we & (wb_rd != 0). It is never asserted for x0.
- Source 0: in_pc + PC_INC, truncated to XLEN bits (wraps modulo 2^XLEN).
- Load extraction (source 2), with off = in_alu_out[log2(XLEN/8)-1:0]:
  - funct3 000 LB / 100 LBU: byte at off, sign-extended or zero-extended.
  - 001 LH / 101 LHU: halfword at off with off[0] ignored, sign-extended or zero-extended.
  - 010 LW: word at off with the low two bits ignored. Sign-extended when XLEN=64; unmodified when XLEN=32.
  - XLEN=64 only: 110 LWU zero-extends the word; 011 LD passes the full doubleword.
  - Any other funct3: raw in_data_out unmodified, no error.
- Misalignment is not trapped here; the ignored offset bits define the result.
- Sources 1 and 3 pass through unchanged.
- Simultaneous flush and stall: flush wins.
- Deassertion of reset while in_valid=1: the first edge after release captures normally.

Optional Feature:
Macro WB_INSTRET_EN.
- When defined: add output instret (64 bits), an instructions-retired counter.
  - Reset value is 0.
  - Increments by 1 on each edge where wb_valid=1 and the register is not held by stall.
  - Each retired instruction is counted exactly once, including instructions with wb_we=0.
  - Wraps at 2^64.
  - A flushed instruction is never counted.
- When not defined: the port and the counter are absent. All other behaviour is identical.

Test Plan:
- Reset: hold reset=0 while applying in_valid=1 -> wb_valid=0, wb_we=0, wb_data=0. Release reset -> the next edge captures.
- Source select: in_pc=0x1000, in_wb_sel=0 -> wb_data=0x1004. Then in_pc=0xFFFFFFFC (XLEN=32) -> wb_data=0x00000000.
- Loads: in_data_out=0x80FF7F01, sel=2.
  - LB off=3 -> 0xFFFFFF80.
  - LBU off=1 -> 0x0000007F.
  - LH off=2 -> 0xFFFF80FF.
  - LHU off=3 -> 0x000080FF.
  - funct3=111 -> 0x80FF7F01.
- Hazards:
  - stall=1 for 3 cycles with changing inputs -> outputs frozen and in_ready=0.
  - flush=1 together with stall=1 -> wb_valid=0 next cycle.
- x0 suppression: in_rd=0, in_reg_we=1, valid -> wb_valid=1, wb_we=0.
- WB_INSTRET_EN: 10 valid instructions including 2 flushed and 3 stall cycles -> instret=8.
